// File: rtl/mips_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mips_mem_arbiter_pkg
// Shared types for the unified-memory arbiter of the multi-cycle MIPS core:
// arbitration mode encoding, response-owner encoding, starvation counter
// width and a small helper that maps grant strobes onto an owner code.
// ----------------------------------------------------------------------------
package mips_mem_arbiter_pkg;

    // Counter wide enough for the largest legal starvation limit (15).
    localparam int unsigned STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        ARB_SHARED    = 2'd0,
        ARB_LOCK_PEND = 2'd1,
        ARB_LOCKED    = 2'd2
    } arb_mode_e;

    typedef enum logic [1:0] {
        ARB_OWN_NONE = 2'd0,
        ARB_OWN_CPU  = 2'd1,
        ARB_OWN_EXT  = 2'd2
    } arb_owner_e;

    // Grants are mutually exclusive; CPU is tested first only for determinism.
    function automatic arb_owner_e owner_of(input logic cpu_grant, input logic ext_grant);
        arb_owner_e own;
        own = ARB_OWN_NONE;
        if (cpu_grant) begin
            own = ARB_OWN_CPU;
        end else if (ext_grant) begin
            own = ARB_OWN_EXT;
        end
        return own;
    endfunction

endpackage

// File: rtl/mips_arb_starve_cnt.sv
// ----------------------------------------------------------------------------
// mips_arb_starve_cnt
// Saturating starvation counter for the external requester.
//   clk, rst          : clock, asynchronous active-high reset
//   inc               : ext waited this cycle (valid but not granted)
//   clr               : ext was granted this cycle (dominates inc)
//   limit_reached_c   : count equals STARVE_LIMIT (decoded from the register)
// ----------------------------------------------------------------------------
module mips_arb_starve_cnt
    import mips_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic limit_reached_c
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] cnt;

    // Clear on grant, otherwise count waiting cycles up to the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT)) begin
            cnt <= cnt + STARVE_CNT_W'(1);
        end
    end

    assign limit_reached_c = (cnt == LIMIT);

endmodule

// File: rtl/mips_mem_arbiter.sv
// ----------------------------------------------------------------------------
// mips_mem_arbiter
// Single-port memory arbiter between the CPU memory port and an external
// requester (loader / debug). One access per cycle, read data returned one
// cycle after acceptance, optional exclusive lock for the ext requester.
//   clk, rst                       : clock, asynchronous active-high reset
//   cpu_valid/we/addr/wdata        : CPU request
//   cpu_ready                      : CPU request accepted (combinational)
//   cpu_rvalid/rdata               : CPU completion, one cycle after accept
//   ext_*                          : same set for the external requester
//   ext_lock / ext_locked          : exclusive-ownership request / status
//   mem_en/we/addr/wdata           : memory macro drive (combinational)
//   mem_rdata                      : memory read data, one cycle after mem_en
// ----------------------------------------------------------------------------
module mips_mem_arbiter
    import mips_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_valid,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              ext_valid,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_ready,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,

    input  logic              ext_lock,
    output logic              ext_locked,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_mode_e  state;
    arb_mode_e  state_next;
    arb_owner_e resp_owner;
    logic       resp_we;

    logic       cpu_grant;
    logic       ext_grant;
    logic       any_grant;
    logic       starve_hit;

    // Starvation tracking for the ext requester.
    mips_arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk             (clk),
        .rst             (rst),
        .inc             (ext_valid && !ext_grant),
        .clr             (ext_grant),
        .limit_reached_c (starve_hit)
    );

    // Mode state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_SHARED;
        end else begin
            state <= state_next;
        end
    end

    // Mode next-state: lock entry waits until no response is due next cycle.
    always_comb begin
        state_next = state;
        case (state)
            ARB_SHARED: begin
                if (ext_lock) begin
                    state_next = ARB_LOCK_PEND;
                end
            end
            ARB_LOCK_PEND: begin
                if (!ext_lock) begin
                    state_next = ARB_SHARED;
                end else if (!any_grant) begin
                    state_next = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (!ext_lock) begin
                    state_next = ARB_SHARED;
                end
            end
            default: begin
                state_next = ARB_SHARED;
            end
        endcase
    end

    // Mode outputs and grant decision. Grants are suppressed while in reset
    // so every output reads 0 for the whole reset window.
    always_comb begin
        cpu_grant  = 1'b0;
        ext_grant  = 1'b0;
        ext_locked = (state == ARB_LOCKED);
        if (!rst) begin
            case (state)
                ARB_SHARED: begin
                    ext_grant = ext_valid && (!cpu_valid || starve_hit);
                    cpu_grant = cpu_valid && !ext_grant;
                end
                default: begin
                    ext_grant = ext_valid;
                end
            endcase
        end
    end

    assign any_grant = cpu_grant || ext_grant;
    assign cpu_ready = cpu_grant;
    assign ext_ready = ext_grant;

    // Memory drive follows the winner in the same cycle; idle bus is all-zero.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_grant) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ext_grant) begin
            mem_en    = 1'b1;
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end
    end

    // Remember who owns the response due next cycle and whether it was a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_owner <= ARB_OWN_NONE;
            resp_we    <= 1'b0;
        end else begin
            resp_owner <= owner_of(cpu_grant, ext_grant);
            resp_we    <= cpu_grant ? cpu_we : (ext_grant && ext_we);
        end
    end

    // Response steering: only the owner sees data, and only for reads.
    always_comb begin
        cpu_rvalid = (resp_owner == ARB_OWN_CPU);
        ext_rvalid = (resp_owner == ARB_OWN_EXT);
        cpu_rdata  = (cpu_rvalid && !resp_we) ? mem_rdata : '0;
        ext_rdata  = (ext_rvalid && !resp_we) ? mem_rdata : '0;
    end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Single-port memory arbiter for the multi-cycle MIPS core. It shares the unified instruction/data memory between the CPU memory port and an external requester (program loader / debug port). It accepts at most one access per cycle and returns read data exactly one cycle after acceptance. It supports an exclusive lock mode so the loader can own memory while the CPU is stalled. The block sits between the CPU datapath memory interface and the synchronous single-port memory macro.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of both requesters and memory
- DATA_W, 32, data width
- STARVE_LIMIT, 4, number of consecutive cycles the ext requester may lose arbitration before it is force-granted; legal range 1..15

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_valid  in  1  CPU request present
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ready  out  1  CPU request accepted this cycle
- cpu_rvalid  out  1  CPU access completed, one cycle after acceptance
- cpu_rdata  out  DATA_W  read data; 0 for write completions
- ext_valid, ext_we, ext_addr, ext_wdata, ext_ready, ext_rvalid, ext_rdata  same directions, widths and meanings for the external requester
- ext_lock  in  1  ext requests exclusive ownership
- ext_locked  out  1  exclusive ownership is active
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en

## Operation
Mode FSM, registered:
- ARB_SHARED
  - Normal arbitration.
  - Goes to ARB_LOCK_PEND when ext_lock=1.
- ARB_LOCK_PEND
  - No new CPU grants; ext grants are still allowed.
  - Goes to ARB_LOCKED on the first cycle with no access in flight, i.e. no rvalid due next cycle.
- ARB_LOCKED
  - ext_locked=1; only ext is granted.
  - Goes to ARB_SHARED when ext_lock=0.
- If ext_lock drops while in ARB_LOCK_PEND, return to ARB_SHARED.

Arbitration in ARB_SHARED (combinational from the valids and registered state):
- Default priority is CPU over ext.
- starve_cnt counts cycles with ext_valid=1 and ext_ready=0. It clears on any ext grant and saturates at STARVE_LIMIT.
- When starve_cnt == STARVE_LIMIT and ext_valid=1, ext wins over the CPU for that cycle.

Grant and memory drive:
- Exactly one of cpu_ready/ext_ready is 1, and only when the matching valid is 1.
- The granted requester drives mem_en=1, mem_we, mem_addr and mem_wdata combinationally in the same cycle.
- With no grant: mem_en=0, mem_we=0, and mem_addr/mem_wdata are 0.

Response tracking:
- Register resp_owner (NONE/CPU/EXT) and resp_we at acceptance.
- On the next cycle, the owner's rvalid=1 and its rdata = mem_rdata for a read, 0 for a write.
- The non-owner's rdata is 0.

Requester obligations:
- Hold valid and all fields stable until ready.
- A requester may issue back-to-back accesses; throughput is 1 access per cycle in total.

## Timing
- Reset values:
  - State ARB_SHARED, starve_cnt=0, resp_owner=NONE.
  - All outputs 0 during and immediately after reset.
- Latency: acceptance at cycle N; rvalid and rdata at cycle N+1. Pipelined: a new acceptance at N+1 is legal alongside the N+1 response.
- Simultaneous valid, no starvation: CPU granted; ext waits, starve_cnt increments.
- Simultaneous valid at starve_cnt == STARVE_LIMIT: ext granted, starve_cnt becomes 0.
- ext_lock with an access in flight: one extra cycle in ARB_LOCK_PEND; ext_locked asserts the cycle after the in-flight rvalid.
- Reset asserted mid-access: the pending response is dropped, no rvalid is emitted, and the mode FSM returns to ARB_SHARED.
- Lock entry/exit is registered: ext_locked changes one cycle after the qualifying condition.
- In ARB_LOCKED, cpu_ready=0 regardless of cpu_valid; the CPU control unit holds its state until ready.

## Structure
- Add to MIPS_pkg:
  - arb_mode_e (ARB_SHARED, ARB_LOCK_PEND, ARB_LOCKED)
  - arb_owner_e (ARB_OWN_NONE, ARB_OWN_CPU, ARB_OWN_EXT)
- One sub-module, mips_arb_starve_cnt: saturating counter with inc, clr and limit-reached output, parameterised by STARVE_LIMIT.
- Everything else is flat in mips_mem_arbiter.

## Test plan
- CPU read at addr 0x10 with mem returning 0xDEADBEEF:
  - cpu_ready=1 and mem_en=1 in cycle N.
  - cpu_rvalid=1 and cpu_rdata=0xDEADBEEF in N+1.
  - ext outputs all 0.
- CPU and ext both valid continuously, STARVE_LIMIT=4:
  - CPU granted 4 cycles, ext granted the 5th, then the pattern repeats.
  - ext_rdata carries only its own responses.
- ext write 0x12345678 to 0x40, then CPU read 0x40 in the next cycle:
  - ext_rvalid=1 with ext_rdata=0.
  - cpu_rdata=0x12345678.
- ext_lock raised while a CPU read is accepted:
  - CPU rvalid completes.
  - ext_locked=1 one cycle after that rvalid.
  - cpu_valid held high gets no ready until ext_lock drops; ext_locked=0 next cycle.
- rst asserted in the cycle after a CPU read acceptance:
  - No cpu_rvalid, all outputs 0, starve_cnt=0.
  - After deassertion, a fresh CPU read completes normally.
